// File: rtl/axi2ahb_cmd_arb_pkg.sv
// Shared types and helpers for the AXI-to-AHB command arbiter.
package axi2ahb_cmd_arb_pkg;

  localparam int CMD_ADDR_BITS = 32;
  localparam int CMD_ID_BITS   = 4;
  localparam logic [12:0] PAGE_BYTES = 13'd4096;

  typedef struct packed {
    logic                     read;
    logic [CMD_ID_BITS-1:0]   id;
    logic [CMD_ADDR_BITS-1:0] addr;
    logic [3:0]               len;
    logic [1:0]               size;
    logic                     err;
  } cmd_t;

  // Largest legal AXI size code for a given bus width: log2(bytes per beat).
  function automatic logic [1:0] max_size(input int data_bits);
    return 2'($clog2(data_bits / 8));
  endfunction

endpackage

// File: rtl/axi2ahb_cmd_chk.sv
// Combinational legality check of a granted AXI address command.
module axi2ahb_cmd_chk
  import axi2ahb_cmd_arb_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [11:0] addr_lo_i,
  input  logic [3:0]  len_i,
  input  logic [1:0]  size_i,
  output logic        err_o
);

  localparam logic [1:0] MAX_SIZE = max_size(DATA_BITS);

  logic        size_err;
  logic        align_err;
  logic        page_err;
  logic [12:0] burst_bytes;
  logic [12:0] burst_end;

  always_comb begin
    size_err = (size_i > MAX_SIZE);
    unique case (size_i)
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = addr_lo_i[0];
      2'd2:    align_err = |addr_lo_i[1:0];
      default: align_err = |addr_lo_i[2:0];
    endcase
    // Ending exactly on the page boundary is legal; only going past it is not.
    burst_bytes = ({9'd0, len_i} + 13'd1) << size_i;
    burst_end   = {1'b0, addr_lo_i} + burst_bytes;
    page_err    = (burst_end > PAGE_BYTES);
    err_o       = size_err | align_err | page_err;
  end

endmodule

// File: rtl/axi2ahb_cmd_arb.sv
// Round-robin AW/AR arbiter feeding one registered command stage, with an
// outstanding-command throttle released by AHB burst completion.
module axi2ahb_cmd_arb
  import axi2ahb_cmd_arb_pkg::*;
#(
  parameter int ADDR_BITS = CMD_ADDR_BITS,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = CMD_ID_BITS,
  parameter int CMD_DEPTH = 4,
  localparam int OUT_BITS = $clog2(CMD_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [ADDR_BITS-1:0] AWADDR,
  input  logic [ID_BITS-1:0]   AWID,
  input  logic [3:0]           AWLEN,
  input  logic [1:0]           AWSIZE,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  input  logic [ADDR_BITS-1:0] ARADDR,
  input  logic [ID_BITS-1:0]   ARID,
  input  logic [3:0]           ARLEN,
  input  logic [1:0]           ARSIZE,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_read,
  output logic [ID_BITS-1:0]   cmd_id,
  output logic [ADDR_BITS-1:0] cmd_addr,
  output logic [3:0]           cmd_len,
  output logic [1:0]           cmd_size,
  output logic                 cmd_err,
  input  logic                 ahb_finish,
  output logic [OUT_BITS-1:0]  outstanding
);

  cmd_t                cmd_q, cmd_d;
  logic                valid_q, valid_d;
  logic                last_rd_q, last_rd_d;
  logic [OUT_BITS-1:0] out_q, out_d;

  logic                 can_accept;
  logic                 grant_r, grant_w;
  logic                 accept, retire;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [3:0]           sel_len;
  logic [1:0]           sel_size;
  logic                 sel_err;

  always_comb begin
    can_accept = (!valid_q || cmd_ready) && (out_q < OUT_BITS'(CMD_DEPTH)) && !reset;
    grant_r    = ARVALID && (!AWVALID || !last_rd_q);
    grant_w    = AWVALID && (!ARVALID || last_rd_q);
    AWREADY    = grant_w && can_accept;
    ARREADY    = grant_r && can_accept;
    accept     = AWREADY || ARREADY;
    retire     = ahb_finish && (out_q != '0);
    sel_addr   = grant_r ? ARADDR : AWADDR;
    sel_len    = grant_r ? ARLEN  : AWLEN;
    sel_size   = grant_r ? ARSIZE : AWSIZE;
  end

  axi2ahb_cmd_chk #(.DATA_BITS(DATA_BITS)) u_chk (
    .addr_lo_i (sel_addr[11:0]),
    .len_i     (sel_len),
    .size_i    (sel_size),
    .err_o     (sel_err)
  );

  always_comb begin
    cmd_d     = cmd_q;
    valid_d   = valid_q;
    last_rd_d = last_rd_q;
    out_d     = out_q;
    if (accept) begin
      cmd_d.read = grant_r;
      cmd_d.id   = grant_r ? ARID : AWID;
      cmd_d.addr = sel_addr;
      cmd_d.len  = sel_len;
      cmd_d.size = sel_size;
      cmd_d.err  = sel_err;
      valid_d    = 1'b1;
      last_rd_d  = grant_r;
    end else if (cmd_ready) begin
      valid_d = 1'b0;
    end
    // Same-cycle accept and retire cancel out.
    if (accept && !retire) out_d = out_q + OUT_BITS'(1);
    else if (retire && !accept) out_d = out_q - OUT_BITS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      last_rd_q <= 1'b0;
      out_q     <= '0;
    end else begin
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      last_rd_q <= last_rd_d;
      out_q     <= out_d;
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_read    = cmd_q.read;
  assign cmd_id      = cmd_q.id;
  assign cmd_addr    = cmd_q.addr;
  assign cmd_len     = cmd_q.len;
  assign cmd_size    = cmd_q.size;
  assign cmd_err     = cmd_q.err;
  assign outstanding = out_q;

endmodule

// File: tb/tb_axi2ahb_cmd_arb.sv
// Directed-vector bench for axi2ahb_cmd_arb with default parameters.
module tb_axi2ahb_cmd_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0]  AWID, ARID, AWLEN, ARLEN;
  logic [1:0]  AWSIZE, ARSIZE;
  logic        cmd_valid, cmd_ready, cmd_read, cmd_err;
  logic [3:0]  cmd_id, cmd_len;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic        ahb_finish;
  logic [2:0]  outstanding;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  axi2ahb_cmd_arb dut (
    .clk(clk), .reset(reset),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_err(cmd_err),
    .ahb_finish(ahb_finish), .outstanding(outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] l,
                         input logic [1:0] s, input logic [3:0] id);
    AWADDR = a; AWLEN = l; AWSIZE = s; AWID = id; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
  endtask

  task automatic finish_one();
    ahb_finish = 1'b1;
    step();
    ahb_finish = 1'b0;
  endtask

  initial begin
    reset = 1'b1; AWVALID = 1'b1; ARVALID = 1'b1;
    AWADDR = '0; ARADDR = '0; AWID = '0; ARID = '0;
    AWLEN = '0; ARLEN = '0; AWSIZE = '0; ARSIZE = '0;
    cmd_ready = 1'b0; ahb_finish = 1'b0;

    // Reset state, with VALIDs high to show READY is held low in reset.
    #3;
    chk("rst_awready", AWREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_fields", {cmd_read, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_err}, 0);
    AWVALID = 1'b0; ARVALID = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1. Single write.
    cmd_ready = 1'b1;
    AWADDR = 32'h1000; AWLEN = 4'd3; AWSIZE = 2'd2; AWID = 4'd5; AWVALID = 1'b1;
    #1;
    chk("t1_awready", AWREADY, 1);
    chk("t1_arready", ARREADY, 0);
    step();
    AWVALID = 1'b0;
    chk("t1_valid", cmd_valid, 1);
    chk("t1_read", cmd_read, 0);
    chk("t1_id", cmd_id, 5);
    chk("t1_addr", cmd_addr, 32'h1000);
    chk("t1_len_size", {cmd_len, cmd_size}, {4'd3, 2'd2});
    chk("t1_err", cmd_err, 0);
    chk("t1_outstanding", outstanding, 1);
    finish_one();
    chk("t1_drained_valid", cmd_valid, 0);
    chk("t1_drained_out", outstanding, 0);

    // 2. Contention with a finish pulse every cycle: R, W, R, W.
    AWADDR = 32'h100; AWID = 4'd3; AWLEN = 4'd0; AWSIZE = 2'd2;
    ARADDR = 32'h200; ARID = 4'd2; ARLEN = 4'd0; ARSIZE = 2'd2;
    AWVALID = 1'b1; ARVALID = 1'b1; ahb_finish = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_arready", ARREADY, (i % 2 == 0));
      chk("t2_awready", AWREADY, (i % 2 != 0));
      step();
      chk("t2_cmd_read", cmd_read, (i % 2 == 0));
      chk("t2_cmd_id", cmd_id, (i % 2 == 0) ? 2 : 3);
      chk("t2_outstanding", outstanding, 1);
    end
    AWVALID = 1'b0; ARVALID = 1'b0;
    step();
    ahb_finish = 1'b0;
    chk("t2_end_out", outstanding, 0);

    // 3. Outstanding limit with six read requests and no completions.
    ARVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_arready", ARREADY, (i < 4));
      step();
    end
    chk("t3_out_full", outstanding, 4);
    ahb_finish = 1'b1;
    #1;
    chk("t3_arready_fin_cycle", ARREADY, 0);
    step();
    ahb_finish = 1'b0;
    chk("t3_out_after_fin", outstanding, 3);
    #1;
    chk("t3_arready_next", ARREADY, 1);
    step();
    ARVALID = 1'b0;
    chk("t3_out_refill", outstanding, 4);
    for (int i = 0; i < 4; i++) finish_one();
    chk("t3_out_drained", outstanding, 0);

    // 4. Error flag vectors.
    send_aw(32'hFF8, 4'd3, 2'd2, 4'd1);
    chk("t4_err_4k_cross", cmd_err, 1);
    finish_one();
    send_aw(32'h102, 4'd0, 2'd2, 4'd1);
    chk("t4_err_unaligned", cmd_err, 1);
    finish_one();
    send_aw(32'h100, 4'd0, 2'd3, 4'd1);
    chk("t4_err_size", cmd_err, 1);
    finish_one();
    send_aw(32'hFF0, 4'd3, 2'd2, 4'd1);
    chk("t4_ok_page_end", cmd_err, 0);
    finish_one();
    send_aw(32'h102, 4'd0, 2'd1, 4'd1);
    chk("t4_ok_half", cmd_err, 0);
    finish_one();
    chk("t4_out", outstanding, 0);

    // 5. Backpressure.
    cmd_ready = 1'b0;
    send_aw(32'h40, 4'd1, 2'd2, 4'd7);
    AWADDR = 32'h80; AWID = 4'd8; AWLEN = 4'd0; AWSIZE = 2'd2; AWVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_awready_held", AWREADY, 0);
      chk("t5_arready_held", ARREADY, 0);
      step();
      chk("t5_valid_held", cmd_valid, 1);
      chk("t5_id_held", cmd_id, 7);
      chk("t5_addr_held", cmd_addr, 32'h40);
      chk("t5_len_held", cmd_len, 1);
    end
    cmd_ready = 1'b1;
    #1;
    chk("t5_awready_release", AWREADY, 1);
    step();
    AWVALID = 1'b0;
    chk("t5_new_valid", cmd_valid, 1);
    chk("t5_new_id", cmd_id, 8);
    chk("t5_new_addr", cmd_addr, 32'h80);
    chk("t5_out", outstanding, 2);
    step();
    chk("t5_drain_valid", cmd_valid, 0);

    // 6. Asynchronous reset mid-operation; last grant before reset is a read.
    cmd_ready = 1'b0;
    ARADDR = 32'h300; ARID = 4'd9; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    chk("t6_pre_valid", cmd_valid, 1);
    chk("t6_pre_read", cmd_read, 1);
    chk("t6_pre_out", outstanding, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_out", outstanding, 0);
    step();
    reset = 1'b0;
    cmd_ready = 1'b1;
    AWVALID = 1'b1; ARVALID = 1'b1; ARID = 4'd4; AWID = 4'd6;
    #1;
    chk("t6_arready", ARREADY, 1);
    chk("t6_awready", AWREADY, 0);
    step();
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk("t6_cmd_read", cmd_read, 1);
    chk("t6_cmd_id", cmd_id, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
